// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: Moore sequencing FSM with main and ALU decoders.
// Produces unconditioned write controls, datapath selects and the IR/PC enables.
module mc_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic [3:0] Rd,
   output logic       PCS,
   output logic       RegW,
   output logic       MemW,
   output logic       NoWrite,
   output logic [1:0] FlagW,
   output logic       NextPC,
   output logic       IRWrite,
   output logic       AdrSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUControl,
   output logic [1:0] ImmSrc,
   output logic [1:0] RegSrc
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   state_t     state_reg;
   state_t     state_next;
   logic       branch;
   logic [1:0] alu_dec;
   logic       is_cmp;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= FETCH;
      else        state_reg <= state_next;
   end

   // ALU decode from cmd; only applied in the execute states
   always_comb begin
      alu_dec = 2'b00;
      is_cmp  = 1'b0;
      case (Funct[4:1])
         4'b0100: alu_dec = 2'b00;
         4'b0010: alu_dec = 2'b01;
         4'b0000: alu_dec = 2'b10;
         4'b1100: alu_dec = 2'b11;
         4'b1010: begin
            alu_dec = 2'b01;
            is_cmp  = 1'b1;
         end
         default: alu_dec = 2'b00;
      endcase
   end

   always_comb begin
      state_next = FETCH;
      branch     = 1'b0;
      RegW       = 1'b0;
      MemW       = 1'b0;
      NoWrite    = 1'b0;
      FlagW      = 2'b00;
      NextPC     = 1'b0;
      IRWrite    = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 2'b00;
      case (state_reg)
         FETCH: begin
            IRWrite    = 1'b1;
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            NextPC     = 1'b1;
            state_next = DECODE;
         end
         DECODE: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            case (Op)
               2'b00:   state_next = Funct[5] ? EXECI : EXECR;
               2'b01:   state_next = MEMADR;
               2'b10:   state_next = BRANCH;
               default: state_next = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcB    = 2'b01;
            state_next = Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc     = 1'b1;
            state_next = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegW      = 1'b1;
         end
         MEMWR: begin
            AdrSrc = 1'b1;
            MemW   = 1'b1;
         end
         EXECR, EXECI: begin
            ALUSrcB    = (state_reg == EXECI) ? 2'b01 : 2'b00;
            ALUControl = alu_dec;
            NoWrite    = is_cmp;
            FlagW      = {Funct[0], Funct[0] & ~alu_dec[1]};
            state_next = ALUWB;
         end
         ALUWB: begin
            // CMP keeps NoWrite up so the downstream gating masks this RegW
            RegW    = 1'b1;
            NoWrite = is_cmp;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            branch    = 1'b1;
         end
         default: state_next = FETCH;
      endcase
   end

   assign PCS    = (RegW & (Rd == 4'hF)) | branch;
   assign ImmSrc = Op;
   assign RegSrc = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: each instruction is expanded into its expected
// per-cycle control vectors by an instruction-level reference model.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       PCS, RegW, MemW, NoWrite, NextPC, IRWrite, AdrSrc, ALUSrcA;
   logic [1:0] FlagW, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;

   typedef struct packed {
      logic       pcs;
      logic       regw;
      logic       memw;
      logic       nowrite;
      logic [1:0] flagw;
      logic       nextpc;
      logic       irwrite;
      logic       adrsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] resultsrc;
      logic [1:0] aluctl;
      logic [1:0] immsrc;
      logic [1:0] regsrc;
   } ctl_t;

   ctl_t got;
   ctl_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_ins = 0;

   mc_controller dut (
      .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
      .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .FlagW(FlagW),
      .NextPC(NextPC), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
      .ImmSrc(ImmSrc), .RegSrc(RegSrc)
   );

   always #5 clk = ~clk;

   assign got = {PCS, RegW, MemW, NoWrite, FlagW, NextPC, IRWrite, AdrSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};

   task automatic check(input string tag, input ctl_t g, input ctl_t e);
      n_cmp++;
      if (g !== e) begin
         n_err++;
         $display("FAIL %s got=%05h exp=%05h", tag, g, e);
      end
   endtask

   function automatic ctl_t idle(input logic [1:0] op);
      ctl_t c = '0;
      c.immsrc = op;
      c.regsrc = {op == 2'b01, op == 2'b10};
      return c;
   endfunction

   function automatic ctl_t fetch_vec(input logic [1:0] op);
      ctl_t c = idle(op);
      c.irwrite   = 1'b1;
      c.nextpc    = 1'b1;
      c.alusrca   = 1'b1;
      c.alusrcb   = 2'b10;
      c.resultsrc = 2'b10;
      return c;
   endfunction

   // Expected control vectors for one whole instruction, cycle by cycle
   function automatic void build(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
      ctl_t c;
      logic [1:0] alu;
      logic cmp, s;
      exp_q.delete();
      exp_q.push_back(fetch_vec(op));
      c = fetch_vec(op);
      c.irwrite = 1'b0;
      c.nextpc  = 1'b0;
      exp_q.push_back(c);
      s = fn[0];
      if (op == 2'b10) begin
         c = idle(op); c.alusrcb = 2'b01; c.resultsrc = 2'b10; c.pcs = 1'b1;
         exp_q.push_back(c);
      end else if (op == 2'b01) begin
         c = idle(op); c.alusrcb = 2'b01;
         exp_q.push_back(c);
         if (fn[0]) begin
            c = idle(op); c.adrsrc = 1'b1;
            exp_q.push_back(c);
            c = idle(op); c.resultsrc = 2'b01; c.regw = 1'b1; c.pcs = (rd == 4'd15);
            exp_q.push_back(c);
         end else begin
            c = idle(op); c.adrsrc = 1'b1; c.memw = 1'b1;
            exp_q.push_back(c);
         end
      end else if (op == 2'b00) begin
         cmp = 1'b0;
         case (fn[4:1])
            4'd4:    alu = 2'd0;
            4'd2:    alu = 2'd1;
            4'd0:    alu = 2'd2;
            4'd12:   alu = 2'd3;
            4'd10:   begin alu = 2'd1; cmp = 1'b1; end
            default: alu = 2'd0;
         endcase
         c = idle(op);
         c.alusrcb = fn[5] ? 2'b01 : 2'b00;
         c.aluctl  = alu;
         c.nowrite = cmp;
         c.flagw   = {s, s & (alu < 2'd2)};
         exp_q.push_back(c);
         c = idle(op); c.regw = 1'b1; c.nowrite = cmp; c.pcs = (rd == 4'd15);
         exp_q.push_back(c);
      end
   endfunction

   // Entered just after a rising edge with the DUT in FETCH; leaves it the same way
   task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
      Op = op; Funct = fn; Rd = rd;
      build(op, fn, rd);
      n_ins++;
      $display("ins %0d op=%b funct=%b rd=%0d cycles=%0d", n_ins, op, fn, rd, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         @(negedge clk);
         check($sformatf("i%0d.c%0d", n_ins, i), got, exp_q[i]);
         @(posedge clk); #1;
      end
   endtask

   task automatic str_abort();
      Op = 2'b01; Funct = 6'b011000; Rd = 4'd3;
      build(Op, Funct, Rd);
      n_ins++;
      $display("ins %0d STR aborted by reset in MEMADR", n_ins);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("abort.c%0d", i), got, exp_q[i]);
         if (i < 2) begin @(posedge clk); #1; end
      end
      #2 reset = 1'b0; Op = 2'b00; Funct = '0; Rd = '0;
      #1 check("abort.async", got, fetch_vec(2'b00));
      @(posedge clk);
      @(negedge clk);
      check("abort.hold", got, fetch_vec(2'b00));
      @(posedge clk); #1 reset = 1'b1;
   endtask

   logic [3:0] cmds [6];

   initial begin
      cmds[0] = 4'd4; cmds[1] = 4'd2; cmds[2] = 4'd0;
      cmds[3] = 4'd12; cmds[4] = 4'd10; cmds[5] = 4'd7;
      reset = 1'b0; Op = 2'b00; Funct = '0; Rd = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset.%0d", i), got, fetch_vec(2'b00));
      end
      @(posedge clk); #1 reset = 1'b1;

      run_instr(2'b00, 6'b101001, 4'd1);    // ADDS R1, immediate
      run_instr(2'b00, 6'b010101, 4'd0);    // CMP
      run_instr(2'b01, 6'b011001, 4'd15);   // LDR R15
      run_instr(2'b01, 6'b011000, 4'd2);    // STR
      run_instr(2'b10, 6'b100000, 4'd0);    // B
      run_instr(2'b11, 6'b000000, 4'd0);    // undefined
      run_instr(2'b00, 6'b011000, 4'd15);   // ORR R15 register, no S
      str_abort();
      run_instr(2'b00, 6'b000101, 4'd4);    // SUBS after reset recovery

      for (int k = 0; k < 60; k++) begin
         logic [1:0] op;
         logic [5:0] fn;
         logic [3:0] rd;
         op = 2'($urandom_range(0, 3));
         fn = 6'($urandom);
         if (op == 2'b00 && $urandom_range(0, 3) != 0)
            fn[4:1] = cmds[$urandom_range(0, 5)];
         rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
         run_instr(op, fn, rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
